cclk_driver: RTL



---
 rtl/cclk_driver.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/cclk_driver.sv
// cclk_driver
//   Drives a single-wire ready line (cclk_out) toward a peer that qualifies it
//   with a stable-high detector, then supervises the peer's returned ready line.
//   Every rise of cclk_out is preceded by LOW_CYCLES consecutive low cycles so
//   the peer detector always restarts cleanly. While high, the peer has
//   TIMEOUT_CYCLES to answer; MAX_RETRIES timeouts are tolerated before FAIL.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   enable     in   level; low forces IDLE and clears everything
//   drop       in   single-cycle request to drop the link and restart the low time
//   peer_ready in   asynchronous ready line from the peer (synchronized here)
//   cclk_out   out  registered ready line to the peer (high in HIGH/LINKED)
//   linked     out  registered, high only in LINKED
//   fail       out  registered, high only in FAIL
//   retries    out  timeouts seen since the last link, saturating at 3
module cclk_driver #(
  parameter int LOW_CYCLES     = 8192,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       drop,
  input  logic       peer_ready,
  output logic       cclk_out,
  output logic       linked,
  output logic       fail,
  output logic [1:0] retries
);

  localparam int MAX_CYC = (LOW_CYCLES > TIMEOUT_CYCLES) ? LOW_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_LINKED,
    ST_FAIL
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retries_q, retries_d;
  logic [1:0]       sync_q, sync_d;
  logic             cclk_out_q, cclk_out_d;
  logic             linked_q, linked_d;
  logic             fail_q, fail_d;
  logic             pr;

  // Two-flop synchronizer; sync_q[1] is the only copy of the peer line
  // that the state logic is allowed to look at.
  assign sync_d = {sync_q[0], peer_ready};
  assign pr     = sync_q[1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;

    if (!enable) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      retries_d = '0;
    end else if (drop && (state_q == ST_LOW || state_q == ST_HIGH || state_q == ST_LINKED)) begin
      // Restart the full low time; a drop is never counted as a retry.
      state_d = ST_LOW;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          cnt_d     = '0;
          retries_d = '0;
          state_d   = ST_LOW;
        end
        ST_LOW: begin
          if (cnt_q == LOW_LAST) begin
            cnt_d   = '0;
            state_d = ST_HIGH;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (pr) begin
            state_d   = ST_LINKED;
            cnt_d     = '0;
            retries_d = '0;
          end else if (cnt_q == TO_LAST) begin
            cnt_d = '0;
            // Terminal check uses the count before this timeout is added.
            if (retries_q == RETRY_MAX) begin
              state_d = ST_FAIL;
            end else begin
              state_d   = ST_LOW;
              retries_d = (retries_q == 2'd3) ? 2'd3 : retries_q + 2'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_LINKED: begin
          // Losing the peer restarts the handshake but is not a timeout.
          if (!pr) begin
            state_d = ST_LOW;
            cnt_d   = '0;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          retries_d = '0;
        end
      endcase
    end

    // Outputs follow the next state so they change on the same edge as it.
    cclk_out_d = (state_d == ST_HIGH) || (state_d == ST_LINKED);
    linked_d   = (state_d == ST_LINKED);
    fail_d     = (state_d == ST_FAIL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      retries_q  <= '0;
      sync_q     <= '0;
      cclk_out_q <= 1'b0;
      linked_q   <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retries_q  <= retries_d;
      sync_q     <= sync_d;
      cclk_out_q <= cclk_out_d;
      linked_q   <= linked_d;
      fail_q     <= fail_d;
    end
  end

  assign cclk_out = cclk_out_q;
  assign linked   = linked_q;
  assign fail     = fail_q;
  assign retries  = retries_q;

endmodule
